// File: rtl/complex_divider.sv
// Complex divider (a+jb)/(c+jd): products, then shared-denominator restoring
// radix-2 division of both components in parallel, one quotient bit per cycle.
module complex_divider #(
  parameter  int N    = 18,
  parameter  int FRAC = 8,
  localparam int ITER = 2*N + FRAC,
  localparam int OW   = 2*N + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N-1:0]  real1,
  input  logic signed [N-1:0]  imag1,
  input  logic signed [N-1:0]  real2,
  input  logic signed [N-1:0]  imag2,
  output logic                 out_valid,
  output logic signed [OW-1:0] realo,
  output logic signed [OW-1:0] imago,
  output logic                 div_zero,
  output logic                 sat
);

  localparam int PW = 2*N;
  localparam int CW = $clog2(ITER);
  // Smallest quotient magnitude that no longer fits as a positive OW-bit value.
  localparam logic [ITER-1:0] MIN_MAG = ITER'(1) << (OW-1);

  typedef enum logic [2:0] {IDLE, PROD, SETUP, DIV, DONE} state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic signed [N-1:0]  a_reg, b_reg, c_reg, d_reg;
  logic signed [PW-1:0] p_ac_reg, p_bd_reg, p_bc_reg, p_ad_reg, p_cc_reg, p_dd_reg;
  logic [PW-1:0]        den_reg;
  logic                 out_valid_reg;
  logic signed [OW-1:0] realo_reg, imago_reg;
  logic                 div_zero_reg, sat_reg;

  logic [1:0][OW-1:0]   num_w;
  logic [1:0][OW-1:0]   res_w;
  logic [1:0]           sat_w;

  assign num_w[0] = OW'(p_ac_reg) + OW'(p_bd_reg);
  assign num_w[1] = OW'(p_bc_reg) - OW'(p_ad_reg);

  // Lane 0 divides the real numerator, lane 1 the imaginary one.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [ITER-1:0] dvd_reg;
      logic [ITER-1:0] quo_reg;
      logic [PW-1:0]   rem_reg;
      logic            neg_reg;
      logic [OW-1:0]   mag;
      logic [PW:0]     rem_shift;
      logic [PW:0]     rem_diff;
      logic            over;

      always_comb begin
        mag       = num_w[gi][OW-1] ? -num_w[gi] : num_w[gi];
        rem_shift = {rem_reg, dvd_reg[ITER-1]};
        // A set MSB means the trial subtraction borrowed: restore.
        rem_diff  = rem_shift - {1'b0, den_reg};
        over      = neg_reg ? (quo_reg > MIN_MAG) : (quo_reg >= MIN_MAG);
      end

      assign sat_w[gi] = over;
      assign res_w[gi] = over ? (neg_reg ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                              : (neg_reg ? -quo_reg[OW-1:0] : quo_reg[OW-1:0]);

      always_ff @(posedge clk) begin
        if (reset) begin
          dvd_reg <= '0;
          quo_reg <= '0;
          rem_reg <= '0;
          neg_reg <= 1'b0;
        end else if (ce) begin
          if (state_reg == SETUP) begin
            neg_reg <= num_w[gi][OW-1];
            dvd_reg <= ITER'(mag) << FRAC;
            quo_reg <= '0;
            rem_reg <= '0;
          end else if (state_reg == DIV) begin
            dvd_reg <= {dvd_reg[ITER-2:0], 1'b0};
            rem_reg <= rem_diff[PW] ? rem_shift[PW-1:0] : rem_diff[PW-1:0];
            quo_reg <= {quo_reg[ITER-2:0], ~rem_diff[PW]};
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      p_ac_reg      <= '0;
      p_bd_reg      <= '0;
      p_bc_reg      <= '0;
      p_ad_reg      <= '0;
      p_cc_reg      <= '0;
      p_dd_reg      <= '0;
      den_reg       <= '0;
      out_valid_reg <= 1'b0;
      realo_reg     <= '0;
      imago_reg     <= '0;
      div_zero_reg  <= 1'b0;
      sat_reg       <= 1'b0;
    end else if (ce) begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= real1;
            b_reg     <= imag1;
            c_reg     <= real2;
            d_reg     <= imag2;
            state_reg <= PROD;
          end
        end
        PROD: begin
          p_ac_reg  <= PW'(a_reg) * PW'(c_reg);
          p_bd_reg  <= PW'(b_reg) * PW'(d_reg);
          p_bc_reg  <= PW'(b_reg) * PW'(c_reg);
          p_ad_reg  <= PW'(a_reg) * PW'(d_reg);
          p_cc_reg  <= PW'(c_reg) * PW'(c_reg);
          p_dd_reg  <= PW'(d_reg) * PW'(d_reg);
          state_reg <= SETUP;
        end
        SETUP: begin
          den_reg   <= $unsigned(p_cc_reg) + $unsigned(p_dd_reg);
          cnt_reg   <= '0;
          state_reg <= DIV;
        end
        DIV: begin
          if (cnt_reg == CW'(ITER-1)) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // A zero divisor bypasses the lanes, whose quotients are meaningless.
          if (den_reg == '0) begin
            realo_reg    <= '0;
            imago_reg    <= '0;
            div_zero_reg <= 1'b1;
            sat_reg      <= 1'b0;
          end else begin
            realo_reg    <= res_w[0];
            imago_reg    <= res_w[1];
            div_zero_reg <= 1'b0;
            sat_reg      <= |sat_w;
          end
          out_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && ce;
  assign out_valid = out_valid_reg;
  assign realo     = realo_reg;
  assign imago     = imago_reg;
  assign div_zero  = div_zero_reg;
  assign sat       = sat_reg;

endmodule

// File: tb/tb_complex_divider.sv
// Directed table vectors, multi-cycle corner sequences and a random sweep
// against an integer model for complex_divider.
module tb_complex_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic in_valid = 1'b0;
  logic in_valid20 = 1'b0;
  logic signed [17:0] real1 = '0, imag1 = '0, real2 = '0, imag2 = '0;

  logic in_ready, out_valid, div_zero, sat;
  logic signed [36:0] realo, imago;
  logic in_ready20, out_valid20, div_zero20, sat20;
  logic signed [36:0] realo20, imago20;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  complex_divider #(.N(18), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .real1(real1), .imag1(imag1), .real2(real2), .imag2(imag2),
    .out_valid(out_valid), .realo(realo), .imago(imago), .div_zero(div_zero), .sat(sat)
  );

  complex_divider #(.N(18), .FRAC(20)) dut20 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid20), .in_ready(in_ready20),
    .real1(real1), .imag1(imag1), .real2(real2), .imag2(imag2),
    .out_valid(out_valid20), .realo(realo20), .imago(imago20), .div_zero(div_zero20), .sat(sat20)
  );

  typedef struct {
    int     a, b, c, d;
    longint re, im;
    bit     dz, st;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic void model(input longint a, input longint b, input longint c, input longint d,
                                output longint re, output longint im, output bit dz, output bit st);
    longint nr, ni, den, lim;
    lim = 64'sd1 <<< 36;
    nr  = a*c + b*d;
    ni  = b*c - a*d;
    den = c*c + d*d;
    dz = (den == 0);
    st = 1'b0;
    re = 0;
    im = 0;
    if (!dz) begin
      re = (nr * 256) / den;
      im = (ni * 256) / den;
      if (re > lim - 1) begin re = lim - 1; st = 1'b1; end
      if (re < -lim)    begin re = -lim;    st = 1'b1; end
      if (im > lim - 1) begin im = lim - 1; st = 1'b1; end
      if (im < -lim)    begin im = -lim;    st = 1'b1; end
    end
  endfunction

  // Issues one operation and counts enabled+disabled edges until out_valid.
  task automatic run_op(input bit use20, input logic signed [17:0] a, input logic signed [17:0] b,
                        input logic signed [17:0] c, input logic signed [17:0] d,
                        input int pause_at, input int glitch_at,
                        output logic signed [36:0] re, output logic signed [36:0] im,
                        output logic dz, output logic st, output int lat);
    logic rdy;
    @(negedge clk);
    real1 = a; imag1 = b; real2 = c; imag2 = d;
    rdy = use20 ? in_ready20 : in_ready;
    check("in_ready_before_issue", 64'(rdy), 64'd1);
    if (use20) in_valid20 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid20 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (use20 ? out_valid20 : out_valid) begin
        lat = i;
        break;
      end
      if (pause_at != 0 && i == pause_at) ce = 1'b0;
      if (pause_at != 0 && i == pause_at + 5) ce = 1'b1;
      if (glitch_at != 0 && i == glitch_at) begin
        in_valid = 1'b1; real1 = 18'sd77; imag1 = -18'sd3; real2 = 18'sd2; imag2 = 18'sd9;
      end
      if (glitch_at != 0 && i == glitch_at + 1) in_valid = 1'b0;
    end
    re = use20 ? realo20 : realo;
    im = use20 ? imago20 : imago;
    dz = use20 ? div_zero20 : div_zero;
    st = use20 ? sat20 : sat;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [36:0] re, im;
    logic dz, st;
    int lat;
    logic signed [17:0] ra, rb, rc, rd;
    longint ere, eim;
    bit edz, est;
    bit seen;

    vecs[0]  = '{a: 4,       b: 2,       c: 1,       d: 1,       re: 768,       im: -256,     dz: 0, st: 0};
    vecs[1]  = '{a: 1,       b: 0,       c: 3,       d: 0,       re: 85,        im: 0,        dz: 0, st: 0};
    vecs[2]  = '{a: -1,      b: 0,       c: 3,       d: 0,       re: -85,       im: 0,        dz: 0, st: 0};
    vecs[3]  = '{a: 5,       b: -7,      c: 0,       d: 0,       re: 0,         im: 0,        dz: 1, st: 0};
    vecs[4]  = '{a: 0,       b: 1,       c: 0,       d: 1,       re: 256,       im: 0,        dz: 0, st: 0};
    vecs[5]  = '{a: 3,       b: 4,       c: 3,       d: -4,      re: -71,       im: 245,      dz: 0, st: 0};
    vecs[6]  = '{a: -131072, b: 131071,  c: 1,       d: 0,       re: -33554432, im: 33554176, dz: 0, st: 0};
    vecs[7]  = '{a: 100,     b: -50,     c: -7,      d: 3,       re: -3751,     im: 220,      dz: 0, st: 0};
    vecs[8]  = '{a: 0,       b: 0,       c: 5,       d: 5,       re: 0,         im: 0,        dz: 0, st: 0};
    vecs[9]  = '{a: -131072, b: -131072, c: -131072, d: -131072, re: 256,       im: 0,        dz: 0, st: 0};
    vecs[10] = '{a: 7,       b: -9,      c: 0,       d: 0,       re: 0,         im: 0,        dz: 1, st: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_in_ready20", 64'(in_ready20), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_realo", 64'(realo), 64'd0);
    check("rst_imago", 64'(imago), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    ce = 1'b0; #1;
    check("ready_needs_ce", 64'(in_ready), 64'd0);
    ce = 1'b1;

    // Directed table, back-to-back issue
    for (int v = 0; v < 11; v++) begin
      run_op(1'b0, 18'(vecs[v].a), 18'(vecs[v].b), 18'(vecs[v].c), 18'(vecs[v].d), 0, 0, re, im, dz, st, lat);
      $display("vec %0d: (%0d,%0d)/(%0d,%0d) -> re=%0d im=%0d dz=%0d sat=%0d lat=%0d",
               v, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, re, im, dz, st, lat);
      check("vec_realo", 64'(re), vecs[v].re);
      check("vec_imago", 64'(im), vecs[v].im);
      check("vec_div_zero", 64'(dz), 64'(vecs[v].dz));
      check("vec_sat", 64'(st), 64'(vecs[v].st));
      check("vec_latency", 64'(lat), 64'd47);
    end

    // FRAC=20 instance: negative and positive saturation, plus one in range
    run_op(1'b1, -18'sd131072, -18'sd131072, 18'sd1, 18'sd0, 0, 0, re, im, dz, st, lat);
    $display("frac20 sat_neg: re=%0d im=%0d sat=%0d lat=%0d", re, im, st, lat);
    check("f20_neg_realo", 64'(re), -(64'sd1 <<< 36));
    check("f20_neg_imago", 64'(im), -(64'sd1 <<< 36));
    check("f20_neg_sat", 64'(st), 64'd1);
    check("f20_neg_dz", 64'(dz), 64'd0);
    check("f20_latency", 64'(lat), 64'd59);
    run_op(1'b1, 18'sd131071, 18'sd0, 18'sd1, 18'sd0, 0, 0, re, im, dz, st, lat);
    $display("frac20 sat_pos: re=%0d im=%0d sat=%0d lat=%0d", re, im, st, lat);
    check("f20_pos_realo", 64'(re), 64'sd68719476735);
    check("f20_pos_imago", 64'(im), 64'sd0);
    check("f20_pos_sat", 64'(st), 64'd1);
    run_op(1'b1, 18'sd1, 18'sd0, 18'sd3, 18'sd0, 0, 0, re, im, dz, st, lat);
    $display("frac20 third: re=%0d im=%0d sat=%0d lat=%0d", re, im, st, lat);
    check("f20_third_realo", 64'(re), 64'sd349525);
    check("f20_third_sat", 64'(st), 64'd0);

    // ce low for 5 cycles mid-DIV delays the result by exactly 5
    run_op(1'b0, 18'sd4, 18'sd2, 18'sd1, 18'sd1, 10, 0, re, im, dz, st, lat);
    $display("ce_pause: re=%0d im=%0d lat=%0d", re, im, lat);
    check("pause_latency", 64'(lat), 64'd52);
    check("pause_realo", 64'(re), 64'sd768);
    check("pause_imago", 64'(im), -64'sd256);

    // out_valid held while ce is low, cleared on the next enabled edge
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_out_valid", 64'(out_valid), 64'd1);
    check("hold_realo", 64'(realo), 64'sd768);
    check("hold_in_ready_ce_low", 64'(in_ready), 64'd0);
    ce = 1'b1;
    @(posedge clk); #1;
    check("hold_release_out_valid", 64'(out_valid), 64'd0);
    check("hold_release_realo", 64'(realo), 64'sd768);
    $display("ce_hold: out_valid=%0d realo=%0d after release", out_valid, realo);

    // in_valid pulsed mid-operation is ignored
    run_op(1'b0, 18'sd4, 18'sd2, 18'sd1, 18'sd1, 0, 8, re, im, dz, st, lat);
    check("glitch_realo", 64'(re), 64'sd768);
    check("glitch_imago", 64'(im), -64'sd256);
    check("glitch_latency", 64'(lat), 64'd47);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("glitch_no_extra_result", 64'(seen), 64'd0);
    $display("glitch: re=%0d im=%0d lat=%0d extra=%0d", re, im, lat, seen);

    // Reset mid-DIV aborts with no pulse and clears outputs
    @(negedge clk);
    real1 = 18'sd4; imag1 = 18'sd2; real2 = 18'sd1; imag2 = 18'sd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_realo", 64'(realo), 64'd0);
    check("abort_imago", 64'(imago), 64'd0);
    check("abort_div_zero", 64'(div_zero), 64'd0);
    check("abort_sat", 64'(sat), 64'd0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_pulse", 64'(seen), 64'd0);
    $display("reset_abort: out_valid_seen=%0d realo=%0d", seen, realo);

    // Random sweep against the integer model
    for (int n = 0; n < 1000; n++) begin
      if (n % 2 == 0) begin
        ra = $signed(18'($urandom)); rb = $signed(18'($urandom));
        rc = $signed(18'($urandom)); rd = $signed(18'($urandom));
      end else begin
        ra = 18'($signed($urandom_range(40)) - 20); rb = 18'($signed($urandom_range(40)) - 20);
        rc = 18'($signed($urandom_range(6)) - 3);   rd = 18'($signed($urandom_range(6)) - 3);
      end
      if (n % 97 == 5) begin rc = '0; rd = '0; end
      model(longint'(ra), longint'(rb), longint'(rc), longint'(rd), ere, eim, edz, est);
      run_op(1'b0, ra, rb, rc, rd, 0, 0, re, im, dz, st, lat);
      $display("rnd %0d: (%0d,%0d)/(%0d,%0d) -> re=%0d im=%0d dz=%0d sat=%0d lat=%0d",
               n, ra, rb, rc, rd, re, im, dz, st, lat);
      check("rnd_realo", 64'(re), ere);
      check("rnd_imago", 64'(im), eim);
      check("rnd_div_zero", 64'(dz), 64'(edz));
      check("rnd_sat", 64'(st), 64'(est));
      check("rnd_latency", 64'(lat), 64'd47);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
